// File: rtl/gpioemu_pkg.sv
// Shared constants and state encodings for the gpioemu host-side bus initiator.
package gpioemu_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  // STATUS[1:0] = {ready, valid}; valid clear on completion means the product overflowed 32 bits
  localparam logic [1:0]  STATUS_DONE  = 2'b11;
  localparam int unsigned STATUS_READY = 1;

  typedef enum logic [3:0] {
    StIdle, StWrA1, StWrA2, StWrCtrl, StPoll, StGap, StRdW, StRdL, StResp
  } host_state_e;

  typedef enum logic [1:0] {
    PhIdle, PhSetup, PhStrobe, PhHold
  } xfer_phase_e;

endpackage

// File: rtl/gpioemu_bus_xfer.sv
// Single gpioemu register access: setup, STROBE_LEN strobe-high cycles, hold.
module gpioemu_bus_xfer
  import gpioemu_pkg::*;
#(
  parameter int unsigned STROBE_LEN = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  xfer_phase_e phase_q, phase_d;
  logic        we_q, we_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        swr_q, swr_d;
  logic        srd_q, srd_d;

  always_comb begin
    phase_d = phase_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    swr_d   = swr_q;
    srd_d   = srd_q;
    case (phase_q)
      // A new access may start in the hold cycle so accesses run back-to-back
      PhIdle, PhHold: begin
        if (start) begin
          phase_d = PhSetup;
          we_d    = we;
          addr_d  = addr;
          if (we) wdata_d = wdata;
        end else begin
          phase_d = PhIdle;
        end
      end
      PhSetup: begin
        phase_d = PhStrobe;
        cnt_d   = '0;
        swr_d   = we_q;
        srd_d   = ~we_q;
      end
      PhStrobe: begin
        if (cnt_q == STROBE_LEN - 1) begin
          phase_d = PhHold;
          swr_d   = 1'b0;
          srd_d   = 1'b0;
          if (!we_q) rdata_d = sdata_in;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: phase_d = PhIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase_q <= PhIdle;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      swr_q   <= 1'b0;
      srd_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      swr_q   <= swr_d;
      srd_q   <= srd_d;
    end
  end

  assign done      = (phase_q == PhHold);
  assign rdata     = rdata_q;
  assign saddress  = addr_q;
  assign sdata_out = wdata_q;
  assign swr       = swr_q;
  assign srd       = srd_q;

endmodule

// File: rtl/gpioemu_host.sv
// Host-side initiator for gpioemu: write operands, trigger, poll status, read W and L back.
module gpioemu_host
  import gpioemu_pkg::*;
#(
  parameter int unsigned STROBE_LEN = 2,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_w,
  output logic [23:0] rsp_l,
  output logic        rsp_ovf,
  output logic        rsp_timeout,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  host_state_e state_q, state_d;
  logic [23:0] a2_q, a2_d;
  logic [31:0] poll_q, poll_d;
  logic [31:0] gap_q, gap_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_w_q, rsp_w_d;
  logic [23:0] rsp_l_q, rsp_l_d;
  logic        rsp_ovf_q, rsp_ovf_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  logic        xs_start, xs_we, xs_done;
  logic [15:0] xs_addr;
  logic [31:0] xs_wdata, xs_rdata;

  always_comb begin
    state_d       = state_q;
    a2_d          = a2_q;
    poll_d        = poll_q;
    gap_d         = gap_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_w_d       = rsp_w_q;
    rsp_l_d       = rsp_l_q;
    rsp_ovf_d     = rsp_ovf_q;
    rsp_timeout_d = rsp_timeout_q;
    xs_start      = 1'b0;
    xs_we         = 1'b0;
    xs_addr       = ADDR_CTRL;
    xs_wdata      = '0;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          a2_d          = cmd_a2;
          poll_d        = '0;
          rsp_w_d       = '0;
          rsp_l_d       = '0;
          rsp_ovf_d     = 1'b0;
          rsp_timeout_d = 1'b0;
          xs_start      = 1'b1;
          xs_we         = 1'b1;
          xs_addr       = ADDR_A1;
          xs_wdata      = {8'h00, cmd_a1};
          state_d       = StWrA1;
        end
      end
      StWrA1: begin
        if (xs_done) begin
          xs_start = 1'b1;
          xs_we    = 1'b1;
          xs_addr  = ADDR_A2;
          xs_wdata = {8'h00, a2_q};
          state_d  = StWrA2;
        end
      end
      StWrA2: begin
        if (xs_done) begin
          xs_start = 1'b1;
          xs_we    = 1'b1;
          xs_addr  = ADDR_CTRL;
          xs_wdata = 32'h1;
          state_d  = StWrCtrl;
        end
      end
      StWrCtrl: begin
        if (xs_done) begin
          xs_start = 1'b1;
          poll_d   = poll_q + 32'd1;
          state_d  = StPoll;
        end
      end
      StPoll: begin
        if (xs_done) begin
          if (xs_rdata[STATUS_READY]) begin
            rsp_ovf_d = (xs_rdata[1:0] != STATUS_DONE);
            xs_start  = 1'b1;
            xs_addr   = ADDR_W;
            state_d   = StRdW;
          end else if (poll_q >= POLL_LIMIT) begin
            rsp_timeout_d = 1'b1;
            rsp_valid_d   = 1'b1;
            state_d       = StResp;
          end else if (POLL_GAP == 0) begin
            xs_start = 1'b1;
            poll_d   = poll_q + 32'd1;
          end else begin
            gap_d   = '0;
            state_d = StGap;
          end
        end
      end
      // The next poll is launched in the last gap cycle so its setup follows immediately
      StGap: begin
        if (gap_q == POLL_GAP - 1) begin
          xs_start = 1'b1;
          poll_d   = poll_q + 32'd1;
          state_d  = StPoll;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      StRdW: begin
        if (xs_done) begin
          rsp_w_d  = xs_rdata;
          xs_start = 1'b1;
          xs_addr  = ADDR_L;
          state_d  = StRdL;
        end
      end
      StRdL: begin
        if (xs_done) begin
          rsp_l_d     = xs_rdata[23:0];
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= StIdle;
      a2_q          <= '0;
      poll_q        <= '0;
      gap_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_w_q       <= '0;
      rsp_l_q       <= '0;
      rsp_ovf_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a2_q          <= a2_d;
      poll_q        <= poll_d;
      gap_q         <= gap_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_w_q       <= rsp_w_d;
      rsp_l_q       <= rsp_l_d;
      rsp_ovf_q     <= rsp_ovf_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  gpioemu_bus_xfer #(
    .STROBE_LEN(STROBE_LEN)
  ) u_xfer (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (xs_start),
    .we       (xs_we),
    .addr     (xs_addr),
    .wdata    (xs_wdata),
    .done     (xs_done),
    .rdata    (xs_rdata),
    .saddress (saddress),
    .swr      (swr),
    .srd      (srd),
    .sdata_out(sdata_out),
    .sdata_in (sdata_in)
  );

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_w       = rsp_w_q;
  assign rsp_l       = rsp_l_q;
  assign rsp_ovf     = rsp_ovf_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: doc/gpioemu_host.md
# gpioemu_host

Bus initiator that drives the gpioemu multiply/popcount peripheral from the host side of its `saddress`/`srd`/`swr` register interface. It accepts a two-operand command, writes both operands, triggers the operation and polls the status register until done. It then reads back the product and the ones-count and returns them on a valid/ready response port. It sits between a host-side sequencer or CPU shim and one gpioemu instance. It generates the edge-sensitive read/write strobes that gpioemu expects.

## Interface
Parameters:
- `STROBE_LEN`, default 2: cycles `srd`/`swr` is held high per access (≥1).
- `POLL_GAP`, default 4: idle cycles between consecutive status polls (≥0).
- `POLL_LIMIT`, default 1024: maximum status polls before timeout (≥1).

Ports:
- `clk` in 1: clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_a1` in 24, `cmd_a2` in 24: operands.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_w` out 32: product bits [31:0].
- `rsp_l` out 24: ones-count.
- `rsp_ovf` out 1: product exceeded 32 bits (status bit0 was 0).
- `rsp_timeout` out 1: poll limit exhausted.
- `saddress` out 16: register address to peripheral.
- `swr` out 1, `srd` out 1: write/read strobes (peripheral acts on rising edge).
- `sdata_out` out 32: write data to the peripheral's `sdata_in`.
- `sdata_in` in 32: read data from the peripheral's `sdata_out`.

## Operation
- Address map: A1 0x0380, A2 0x0388, W 0x0390, L 0x0398, CTRL/STATUS 0x03A0. STATUS[1:0] = {ready, valid}. Done is STATUS[1:0] == 2'b11.
- FSM states: IDLE → WR_A1 → WR_A2 → WR_CTRL → POLL ⇄ GAP → RD_W → RD_L → RESP → IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_a1` and `cmd_a2`, drop `cmd_ready`, enter WR_A1.
- WR_A1/WR_A2: write the operand zero-extended to 32 bits. WR_CTRL: write 32'h1.
- POLL: read STATUS and increment the poll counter.
  - Done → RD_W.
  - Not done, counter < POLL_LIMIT → GAP for POLL_GAP cycles, then POLL.
  - Not done, counter == POLL_LIMIT → RESP with `rsp_timeout`=1, `rsp_w`=0, `rsp_l`=0, `rsp_ovf`=0.
- `rsp_ovf` = ~STATUS[0] from the final (done) poll.
- RD_W captures `sdata_in` into `rsp_w`. RD_L captures `sdata_in[23:0]` into `rsp_l`.
- RESP: `rsp_valid`=1 with fields stable until `rsp_ready`. After the handshake, go to IDLE. `cmd_ready` rises the next cycle.
- Only one command is in flight; `cmd_valid` outside IDLE is ignored.
- Reset (any state): asynchronously go to IDLE.
  - Reset values: `saddress`=0, `swr`=0, `srd`=0, `sdata_out`=0, `cmd_ready`=0 during reset then 1 in first IDLE cycle, `rsp_valid`=0, `rsp_w`=0, `rsp_l`=0, `rsp_ovf`=0, `rsp_timeout`=0, poll counter 0.
  - Any in-progress strobe is dropped immediately.

## Timing
- Every bus access is STROBE_LEN+2 cycles:
  - 1 setup cycle: `saddress`/`sdata_out` valid, strobe low.
  - STROBE_LEN strobe-high cycles.
  - 1 hold cycle: address held, strobe low.
- `srd` and `swr` are never high together. Address and write data never change while a strobe is high.
- Read data is sampled on the last strobe-high cycle (≥1 cycle after the rising edge).
- Accesses are back-to-back with no extra gap, except GAP between polls.
- All outputs are registered; no combinational path from `sdata_in` or `cmd_*` to the bus outputs.
- Latency, done on first poll, defaults: 6 accesses × 4 = 24 cycles from command accept to `rsp_valid`.
- Each extra poll adds POLL_GAP + STROBE_LEN + 2 cycles.

## Structure
- Package `gpioemu_pkg` holds:
  - address constants `ADDR_A1`, `ADDR_A2`, `ADDR_W`, `ADDR_L`, `ADDR_CTRL`;
  - `STATUS_DONE` = 2'b11;
  - the FSM state enum.
- One sub-module, `gpioemu_bus_xfer`, performs a single access.
  - Inputs: `start`, `we`, `addr`, `wdata`.
  - Outputs: `done` (one-cycle pulse in the hold cycle), `rdata`, and the bus pins.
- The top FSM sequences `gpioemu_bus_xfer` and owns the poll counter and response registers.

## Test plan
The bench uses a behavioural gpioemu responder model that updates read data on the `srd` rising edge and logs writes on the `swr` rising edge.
- Command a1=3, a2=5; model returns STATUS 01 for 3 polls, then 11, W=0x0000000F, L=4.
  - Writes logged in order: 0x0380←3, 0x0388←5, 0x03A0←1.
  - Exactly 4 status reads.
  - Response w=0x0F, l=4, ovf=0, timeout=0.
- Model returns STATUS 10 on the done poll (ready=1, valid=0), W=0xFFFF0001.
  - Response ovf=1, w=0xFFFF0001.
- Model never reports 11, POLL_LIMIT=8.
  - Exactly 8 status reads, no W/L reads.
  - Response timeout=1, w=0, l=0.
- `rsp_ready` held low 10 cycles.
  - `rsp_valid` and fields stay stable.
  - `cmd_valid` is ignored throughout.
  - `cmd_ready` rises 1 cycle after the handshake.
- Assert `n_reset` while `swr` is high during WR_A2.
  - `swr` drops asynchronously and all outputs take reset values.
  - After release, a new command completes normally.
- Protocol checker on every cycle: `srd`&`swr` never both 1; `saddress`/`sdata_out` stable while a strobe is high; strobe width = STROBE_LEN.
